wb_timer: RTL and testbench

Wishbone responder that implements the RISC-V machine timer (64-bit mtime/mtimecmp) plus a prescaler and a control register. It is a slave on the same single-master bus the cpu drives: the bus forwards strobes for the timer region unchanged, and this block returns data, ack and stall. It raises `o_irq` as the machine timer interrupt request.

---
 rtl/wb_timer.sv | 147 ++++++++++++++
 tb/tb_wb_timer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_timer.sv
// wb_timer: Wishbone responder for the RISC-V machine timer (mtime/mtimecmp),
// with a tick prescaler, a control register and a level timer interrupt.
module wb_timer #(
   parameter logic [15:0] PRESCALE_RST = 16'd0,
   parameter logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_wb_stb,
   input  logic [31:0] i_wb_addr,
   input  logic        i_wb_we,
   input  logic [31:0] i_wb_data,
   input  logic [2:0]  i_wb_sel,
   output logic [31:0] o_wb_data,
   output logic        o_wb_ack,
   output logic        o_wb_stall,
   output logic        o_irq
);

   localparam int unsigned DW = 32;
   localparam int unsigned TW = 64;
   localparam int unsigned PW = 16;

   localparam logic [2:0] A_MTIME_LO = 3'd0;
   localparam logic [2:0] A_MTIME_HI = 3'd1;
   localparam logic [2:0] A_CMP_LO   = 3'd2;
   localparam logic [2:0] A_CMP_HI   = 3'd3;
   localparam logic [2:0] A_CTRL     = 3'd4;
   localparam logic [2:0] A_PRESCALE = 3'd5;

   logic [TW-1:0] mtime, mtime_nxt;
   logic [TW-1:0] mtimecmp, mtimecmp_nxt;
   logic [DW-1:0] shadow, shadow_nxt;
   logic [PW-1:0] prescale, prescale_nxt;
   logic [PW-1:0] pcnt, pcnt_nxt;
   logic          ctrl_en, ctrl_en_nxt;
   logic          ctrl_irq_en, ctrl_irq_en_nxt;
   logic [DW-1:0] rdata_c;
   logic [3:0]    wmask;
   logic [2:0]    reg_sel;
   logic          accept, wr_en, rd_en, tick;
   logic          unused_bits;

   assign unused_bits = ^{i_wb_addr[31:5], i_wb_sel[2]};

   // Single outstanding request: the ack cycle is also the stall cycle.
   assign o_wb_stall = o_wb_ack;
   assign accept     = i_wb_stb && !o_wb_ack;
   assign reg_sel    = i_wb_addr[4:2];
   assign rd_en      = accept && !i_wb_we;
   assign wr_en      = accept && i_wb_we && (wmask != 4'b0000);
   assign tick       = ctrl_en && (pcnt == prescale);

   // Merge the enabled byte lanes of new data into an existing word.
   function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_w,
                                           input logic [DW-1:0] new_w,
                                           input logic [3:0]    m);
      logic [DW-1:0] res;
      for (int i = 0; i < 4; i++) begin
         res[8*i +: 8] = m[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
      end
      return res;
   endfunction

   // Byte-lane mask from size and offset; misaligned accesses yield no lanes.
   always_comb begin
      wmask = 4'b0000;
      case (i_wb_sel[1:0])
         2'b00:   wmask = 4'b0001 << i_wb_addr[1:0];
         2'b01:   wmask = i_wb_addr[0] ? 4'b0000 :
                          (i_wb_addr[1] ? 4'b1100 : 4'b0011);
         default: wmask = (i_wb_addr[1:0] == 2'b00) ? 4'b1111 : 4'b0000;
      endcase
   end

   // Read mux over the pre-edge register contents.
   always_comb begin
      rdata_c = '0;
      case (reg_sel)
         A_MTIME_LO: rdata_c = mtime[31:0];
         A_MTIME_HI: rdata_c = shadow;
         A_CMP_LO:   rdata_c = mtimecmp[31:0];
         A_CMP_HI:   rdata_c = mtimecmp[63:32];
         A_CTRL:     rdata_c = {30'd0, ctrl_irq_en, ctrl_en};
         A_PRESCALE: rdata_c = {16'd0, prescale};
         default:    rdata_c = '0;
      endcase
   end

   // Next state: prescaled counting, with bus writes overriding the tick.
   always_comb begin
      mtime_nxt       = tick ? mtime + 64'd1 : mtime;
      pcnt_nxt        = !ctrl_en ? pcnt : (tick ? '0 : pcnt + 16'd1);
      mtimecmp_nxt    = mtimecmp;
      prescale_nxt    = prescale;
      ctrl_en_nxt     = ctrl_en;
      ctrl_irq_en_nxt = ctrl_irq_en;
      shadow_nxt      = (rd_en && reg_sel == A_MTIME_LO) ? mtime[63:32] : shadow;
      if (wr_en) begin
         case (reg_sel)
            A_MTIME_LO: mtime_nxt = {mtime[63:32], merge(mtime[31:0], i_wb_data, wmask)};
            A_MTIME_HI: mtime_nxt = {merge(mtime[63:32], i_wb_data, wmask), mtime[31:0]};
            A_CMP_LO:   mtimecmp_nxt = {mtimecmp[63:32], merge(mtimecmp[31:0], i_wb_data, wmask)};
            A_CMP_HI:   mtimecmp_nxt = {merge(mtimecmp[63:32], i_wb_data, wmask), mtimecmp[31:0]};
            A_CTRL: begin
               if (wmask[0]) begin
                  ctrl_en_nxt     = i_wb_data[0];
                  ctrl_irq_en_nxt = i_wb_data[1];
               end
            end
            A_PRESCALE: begin
               prescale_nxt = 16'(merge({16'd0, prescale}, i_wb_data, wmask));
               pcnt_nxt     = '0;
            end
            default: ;
         endcase
      end
   end

   // State and registered bus/interrupt outputs.
   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         mtime       <= '0;
         shadow      <= '0;
         mtimecmp    <= MTIMECMP_RST;
         prescale    <= PRESCALE_RST;
         pcnt        <= '0;
         ctrl_en     <= 1'b0;
         ctrl_irq_en <= 1'b0;
         o_wb_ack    <= 1'b0;
         o_wb_data   <= '0;
         o_irq       <= 1'b0;
      end else begin
         mtime       <= mtime_nxt;
         shadow      <= shadow_nxt;
         mtimecmp    <= mtimecmp_nxt;
         prescale    <= prescale_nxt;
         pcnt        <= pcnt_nxt;
         ctrl_en     <= ctrl_en_nxt;
         ctrl_irq_en <= ctrl_irq_en_nxt;
         o_wb_ack    <= accept;
         o_wb_data   <= rd_en ? rdata_c : '0;
         o_irq       <= ctrl_irq_en && (mtime >= mtimecmp);
      end
   end

endmodule

// File: tb/tb_wb_timer.sv
// tb_wb_timer: directed, table-driven bench for wb_timer.
module tb_wb_timer;

   logic        clk = 1'b0;
   logic        rst_l;
   logic        wb_stb, wb_we;
   logic [31:0] wb_addr, wb_data;
   logic [2:0]  wb_sel;
   logic [31:0] wb_rdata;
   logic        wb_ack, wb_stall, irq;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   always #5 clk = ~clk;

   // Edge counter used to timestamp accepted requests.
   always @(posedge clk) cyc <= cyc + 1;

   wb_timer dut (
      .i_clk      (clk),
      .i_reset    (rst_l),
      .i_wb_stb   (wb_stb),
      .i_wb_addr  (wb_addr),
      .i_wb_we    (wb_we),
      .i_wb_data  (wb_data),
      .i_wb_sel   (wb_sel),
      .o_wb_data  (wb_rdata),
      .o_wb_ack   (wb_ack),
      .o_wb_stall (wb_stall),
      .o_irq      (irq)
   );

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] data;
      logic [2:0]  sel;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(input logic we, input logic [31:0] addr,
                               input logic [31:0] data, input logic [2:0] sel,
                               input logic [31:0] exp);
      vec_t v;
      v.we = we; v.addr = addr; v.data = data; v.sel = sel; v.exp = exp;
      vecs.push_back(v);
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   // One bus transaction; returns read data and the accepting edge number.
   task automatic bus(input logic we, input logic [31:0] addr, input logic [31:0] data,
                      input logic [2:0] sel, output logic [31:0] rd, output int acc);
      int n;
      @(negedge clk);
      wb_stb = 1'b1; wb_we = we; wb_addr = addr; wb_data = data; wb_sel = sel;
      n = 0;
      while (wb_stall !== 1'b0 && n < 8) begin
         @(negedge clk);
         n++;
      end
      @(posedge clk);
      #1;
      acc = cyc;
      wb_stb = 1'b0; wb_we = 1'b0;
      @(negedge clk);
      checks++;
      if (wb_ack !== 1'b1) begin
         failures++;
         $display("FAIL ack_timeout addr=%0h actual=%0b required=1", addr, wb_ack);
      end
      rd = wb_rdata;
   endtask

   task automatic wr(input logic [31:0] addr, input logic [31:0] data, output int acc);
      logic [31:0] d;
      bus(1'b1, addr, data, 3'b010, d, acc);
   endtask

   task automatic rd(input logic [31:0] addr, output logic [31:0] d, output int acc);
      bus(1'b0, addr, 32'd0, 3'b010, d, acc);
   endtask

   initial begin
      logic [31:0] d;
      logic [63:0] base;
      int a, e0, r, w, k, acks, stall_acks, bad;

      rst_l = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
      wb_addr = '0; wb_data = '0; wb_sel = 3'b010;

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_ack", 64'(wb_ack), 64'd0);
      chk("rst_stall", 64'(wb_stall), 64'd0);
      chk("rst_data", 64'(wb_rdata), 64'd0);
      chk("rst_irq", 64'(irq), 64'd0);
      rst_l = 1'b1;

      // Register map, sub-word and misaligned accesses
      add(1'b0, 32'h0C, 32'h0, 3'b010, 32'hFFFF_FFFF);
      add(1'b0, 32'h10, 32'h0, 3'b010, 32'h0);
      add(1'b0, 32'h14, 32'h0, 3'b010, 32'h0);
      add(1'b0, 32'h00, 32'h0, 3'b010, 32'h0);
      add(1'b0, 32'h04, 32'h0, 3'b010, 32'h0);
      add(1'b0, 32'h08, 32'h0, 3'b010, 32'hFFFF_FFFF);
      add(1'b1, 32'h10, 32'hFFFF_FFFC, 3'b010, 32'h0);
      add(1'b0, 32'h10, 32'h0, 3'b010, 32'h0);
      add(1'b1, 32'h11, 32'h0000_FF00, 3'b000, 32'h0);
      add(1'b0, 32'h10, 32'h0, 3'b010, 32'h0);
      add(1'b1, 32'h14, 32'hABCD_1234, 3'b010, 32'h0);
      add(1'b0, 32'h14, 32'h0, 3'b010, 32'h0000_1234);
      add(1'b1, 32'h14, 32'h0000_00FF, 3'b001, 32'h0);
      add(1'b1, 32'h15, 32'h0000_AB00, 3'b000, 32'h0);
      add(1'b1, 32'h16, 32'hFFFF_0000, 3'b001, 32'h0);
      add(1'b0, 32'h14, 32'h0, 3'b010, 32'h0000_ABFF);
      add(1'b1, 32'h18, 32'h1234_5678, 3'b010, 32'h0);
      add(1'b0, 32'h18, 32'h0, 3'b010, 32'h0);
      add(1'b0, 32'h1C, 32'h0, 3'b010, 32'h0);
      add(1'b1, 32'h0A, 32'h00AB_0000, 3'b000, 32'h0);
      add(1'b0, 32'h08, 32'h0, 3'b010, 32'hFFAB_FFFF);
      add(1'b1, 32'h09, 32'h1234_1234, 3'b001, 32'h0);
      add(1'b0, 32'h08, 32'h0, 3'b010, 32'hFFAB_FFFF);
      add(1'b1, 32'h0D, 32'h0000_0000, 3'b010, 32'h0);
      add(1'b0, 32'h08, 32'h0, 3'b010, 32'hFFAB_FFFF);
      add(1'b1, 32'h0A, 32'h5555_0000, 3'b001, 32'h0);
      add(1'b0, 32'h08, 32'h0, 3'b010, 32'h5555_FFFF);
      add(1'b1, 32'h0F, 32'h1200_0000, 3'b100, 32'h0);
      add(1'b0, 32'h0C, 32'h0, 3'b010, 32'h12FF_FFFF);
      foreach (vecs[i]) begin
         bus(vecs[i].we, vecs[i].addr, vecs[i].data, vecs[i].sel, d, a);
         chk($sformatf("vec%0d_addr%0h", i, vecs[i].addr), 64'(d), 64'(vecs[i].exp));
      end

      // Counting with PRESCALE=3: mtime after edge e0+j is j/4
      wr(32'h14, 32'd3, a);
      rd(32'h00, d, a);
      chk("count_pre_en", 64'(d), 64'd0);
      wr(32'h10, 32'd1, e0);
      repeat (40) @(negedge clk);
      rd(32'h00, d, r);
      chk("count_40", 64'(d), 64'((r - e0 - 1) / 4));
      chk("count_range", 64'(d >= 32'd9 && d <= 32'd11), 64'd1);
      wr(32'h10, 32'd0, w);
      repeat (12) @(negedge clk);
      rd(32'h00, d, r);
      chk("count_frozen", 64'(d), 64'((w - e0) / 4));

      // Carry across 32 bits and atomic high-word read
      wr(32'h14, 32'd0, a);
      wr(32'h04, 32'd0, a);
      wr(32'h10, 32'd1, a);
      wr(32'h00, 32'hFFFF_FFFE, w);
      base = 64'h0000_0000_FFFF_FFFE;
      rd(32'h00, d, r);
      chk("carry_lo1", 64'(d), 64'((base + 64'(r - 1 - w)) & 64'hFFFF_FFFF));
      chk("carry_lo1_val", 64'(d), 64'hFFFF_FFFF);
      rd(32'h04, d, r);
      chk("carry_hi_shadow", 64'(d), 64'd0);
      rd(32'h00, d, r);
      chk("carry_lo2", 64'(d), 64'((base + 64'(r - 1 - w)) & 64'hFFFF_FFFF));
      rd(32'h04, d, r);
      chk("carry_hi2", 64'(d), 64'd1);
      wr(32'h10, 32'd0, a);

      // Interrupt rise, drop on raised mtimecmp, drop on IRQ_EN clear
      wr(32'h0C, 32'd0, a);
      wr(32'h08, 32'd20, a);
      wr(32'h04, 32'd0, a);
      wr(32'h00, 32'd0, a);
      wr(32'h10, 32'd3, e0);
      chk("irq_idle", 64'(irq), 64'd0);
      k = 0;
      while (cyc < e0 + 20 && k < 100) begin
         @(negedge clk);
         k++;
      end
      chk("irq_before", 64'(irq), 64'd0);
      @(negedge clk);
      chk("irq_rise", 64'(irq), 64'd1);
      wr(32'h08, 32'd100, w);
      chk("irq_hold_cmp", 64'(irq), 64'd1);
      @(negedge clk);
      chk("irq_drop_cmp", 64'(irq), 64'd0);
      wr(32'h08, 32'd10, w);
      @(negedge clk);
      chk("irq_rise2", 64'(irq), 64'd1);
      wr(32'h10, 32'd1, w);
      chk("irq_hold_en", 64'(irq), 64'd1);
      @(negedge clk);
      chk("irq_drop_en", 64'(irq), 64'd0);
      wr(32'h10, 32'd0, a);

      // Strobe held for 6 edges: 3 accepts, stall only on ack cycles
      @(negedge clk);
      wb_stb = 1'b1; wb_we = 1'b0; wb_addr = 32'h10; wb_sel = 3'b010;
      acks = 0; stall_acks = 0; bad = 0;
      for (int j = 0; j < 8; j++) begin
         @(posedge clk);
         #1;
         if (j == 5) wb_stb = 1'b0;
         @(negedge clk);
         if (wb_ack) acks++;
         if (wb_ack && wb_stall) stall_acks++;
         if (wb_ack !== wb_stall) bad++;
      end
      chk("hs_acks", 64'(acks), 64'd3);
      chk("hs_stall_on_ack", 64'(stall_acks), 64'd3);
      chk("hs_stall_eq_ack", 64'(bad), 64'd0);

      // Reset at the accept edge drops the request
      wr(32'h08, 32'd77, a);
      @(negedge clk);
      wb_stb = 1'b1; wb_we = 1'b0; wb_addr = 32'h08; rst_l = 1'b0;
      @(posedge clk);
      #1;
      wb_stb = 1'b0;
      @(negedge clk);
      chk("rst_req_ack0", 64'(wb_ack), 64'd0);
      @(negedge clk);
      chk("rst_req_ack1", 64'(wb_ack), 64'd0);
      rst_l = 1'b1;
      rd(32'h08, d, a);
      chk("rst_cmp_lo", 64'(d), 64'hFFFF_FFFF);
      rd(32'h04, d, a);
      chk("rst_shadow", 64'(d), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
